mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter sharing one synchronous RAM between the
// processor sequencer (port 0) and a secondary master (port 1).
// Each request costs a CS strobe cycle, an extra capture cycle for reads,
// a done cycle, and an IDLE turnaround cycle.
// Backpressure: a requester holds req until it sees its done pulse; a losing
// requester simply stays pending until a later IDLE cycle grants it.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// without it port 0 has fixed priority.
// Ports:
//   clock, n_reset                  clock, async active-low reset
//   i_req*/i_we*/i_addr*/i_wdata*   per-port request, latched in IDLE
//   o_gnt*/o_done*                  ownership level / completion pulse
//   o_rdata, o_busy                 registered read data, FSM not idle
//   o_mem_*, i_mem_rdata            RAM pins
module mem_arbiter #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [WORD_W-1:0] i_wdata0,
  input  logic [WORD_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_done0,
  output logic              o_done1,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_busy,
  output logic              o_mem_cs,
  output logic              o_mem_r_nw,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  input  logic [WORD_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READ   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_owner;     // 0 = port 0, 1 = port 1
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [WORD_W-1:0]   r_rdata;
  logic                w_any_req;
  logic                w_sel1;      // winner of the current IDLE cycle is port 1

  assign w_any_req = i_req0 | i_req1;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_owner;

  // On a tie the port that was not served last wins; otherwise whoever asks.
  assign w_sel1 = (i_req0 & i_req1) ? ~r_last_owner : i_req1;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_last_owner <= 1'b1;
    end else if (r_state == DONE) begin
      r_last_owner <= r_owner;
    end
  end
`else
  // Port 0 always wins; port 1 is chosen only when port 0 is quiet.
  assign w_sel1 = ~i_req0;
`endif

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Transaction latch: inputs are only looked at in IDLE, so a requester may
  // change or drop them afterwards without disturbing the access in flight.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == IDLE && w_any_req) begin
        r_owner <= w_sel1;
        r_we    <= w_sel1 ? i_we1    : i_we0;
        r_addr  <= w_sel1 ? i_addr1  : i_addr0;
        r_wdata <= w_sel1 ? i_wdata1 : i_wdata0;
      end
      // RAM output is valid the cycle after the CS read strobe.
      if (r_state == READ) begin
        r_rdata <= i_mem_rdata;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_gnt0       = 1'b0;
    o_gnt1       = 1'b0;
    o_done0      = 1'b0;
    o_done1      = 1'b0;
    o_busy       = 1'b0;
    o_mem_cs     = 1'b0;
    o_mem_r_nw   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        o_busy       = 1'b1;
        o_gnt0       = ~r_owner;
        o_gnt1       = r_owner;
        o_mem_cs     = 1'b1;
        o_mem_r_nw   = ~r_we;
        w_next_state = r_we ? DONE : READ;
      end
      READ: begin
        o_busy       = 1'b1;
        o_gnt0       = ~r_owner;
        o_gnt1       = r_owner;
        w_next_state = DONE;
      end
      DONE: begin
        o_busy       = 1'b1;
        o_gnt0       = ~r_owner;
        o_gnt1       = r_owner;
        o_done0      = ~r_owner;
        o_done1      = r_owner;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_rdata     = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table of single-port transactions, hand
// sequences for reset abort, ties, early req drop and held req, then random
// two-port traffic compared cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       n_reset;
  logic       req   [2];
  logic       we    [2];
  logic [4:0] addr  [2];
  logic [7:0] wdata [2];
  logic       gnt0, gnt1, done0, done1, busy, mem_cs, mem_r_nw;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic [4:0] mem_addr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] ref_mem [32];
  logic [7:0] prev_rd;

  mem_arbiter #(.WORD_W(8), .ADDR_W(5)) dut (
    .clock(clock), .n_reset(n_reset),
    .i_req0(req[0]), .i_req1(req[1]), .i_we0(we[0]), .i_we1(we[1]),
    .i_addr0(addr[0]), .i_addr1(addr[1]), .i_wdata0(wdata[0]), .i_wdata1(wdata[1]),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
    .o_rdata(rdata), .o_busy(busy), .o_mem_cs(mem_cs), .o_mem_r_nw(mem_r_nw),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous RAM; unwritten locations read back as 0x40 + address.
  logic [7:0] ram [32];
  bit         ram_wr [32];
  always @(posedge clock) begin
    if (mem_cs) begin
      if (!mem_r_nw) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : 8'h40 + {3'b000, mem_addr};
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic gnt_of(input int p);
    return (p != 0) ? gnt1 : gnt0;
  endfunction

  function automatic logic done_of(input int p);
    return (p != 0) ? done1 : done0;
  endfunction

  task automatic wait_gnt(input string nm, output int owner);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(gnt0 || gnt1) && n < 10);
    check({nm, ".gnt_seen"}, 32'(gnt0 | gnt1), 32'd1);
    check({nm, ".gnt_excl"}, 32'(gnt0 & gnt1), 32'd0);
    owner = gnt1 ? 1 : 0;
  endtask

  task automatic wait_done(input string nm, input int p);
    int n = 0;
    while (!done_of(p) && n < 10) begin
      step();
      n++;
    end
    check({nm, ".done_seen"}, 32'(done_of(p)), 32'd1);
  endtask

  typedef struct {
    int         port;
    bit         we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  task automatic do_txn(input vec_t v, input string nm);
    int p = v.port;
    int q = 1 - v.port;
    req[p] = 1'b1; we[p] = v.we; addr[p] = v.addr; wdata[p] = v.wdata;
    step();  // ACCESS
    check({nm, ".cs"}, 32'(mem_cs), 32'd1);
    check({nm, ".r_nw"}, 32'(mem_r_nw), 32'(!v.we));
    check({nm, ".addr"}, 32'(mem_addr), 32'(v.addr));
    check({nm, ".wdata"}, 32'(mem_wdata), 32'(v.wdata));
    check({nm, ".gnt"}, 32'(gnt_of(p)), 32'd1);
    check({nm, ".gnt_other"}, 32'(gnt_of(q)), 32'd0);
    if (v.we) begin
      ref_mem[v.addr] = v.wdata;
      step();  // DONE
      check({nm, ".done"}, 32'(done_of(p)), 32'd1);
      check({nm, ".rdata_kept"}, 32'(rdata), 32'(prev_rd));
    end else begin
      step();  // READ
      check({nm, ".read_cs"}, 32'(mem_cs), 32'd0);
      check({nm, ".read_done"}, 32'(done_of(p)), 32'd0);
      step();  // DONE
      check({nm, ".done"}, 32'(done_of(p)), 32'd1);
      check({nm, ".rdata"}, 32'(rdata), 32'(v.exp_rd));
      check({nm, ".done_gnt_other"}, 32'(gnt_of(q)), 32'd0);
      prev_rd = v.exp_rd;
    end
    req[p] = 1'b0;
    step();  // IDLE
    check({nm, ".idle_busy"}, 32'(busy), 32'd0);
    check({nm, ".idle_done"}, 32'(done_of(p)), 32'd0);
  endtask

  initial begin
    vec_t tbl [7];
    int   owner, cnt, np, d1, d2;
    // model state for the random phase
    bit         t_v;
    int         t_start, t_len, t_own;
    bit         t_we;
    logic [4:0] t_addr, m_addr;
    logic [7:0] m_wdata, m_rd;
    int         m_last;
    bit         pend [2];
    bit         latched [2];

    tbl[0] = '{0, 1'b1, 5'h03, 8'hA5, 8'h00};
    tbl[1] = '{1, 1'b0, 5'h03, 8'h00, 8'hA5};
    tbl[2] = '{1, 1'b1, 5'h1F, 8'h3C, 8'h00};
    tbl[3] = '{0, 1'b0, 5'h1F, 8'h00, 8'h3C};
    tbl[4] = '{1, 1'b0, 5'h02, 8'h00, 8'h42};
    tbl[5] = '{0, 1'b1, 5'h10, 8'hFF, 8'h00};
    tbl[6] = '{1, 1'b0, 5'h10, 8'h00, 8'hFF};

    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h40 + 8'(i);
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
    end
    prev_rd = 8'h00;

    // Reset values, then abort a write in ACCESS with an async reset.
    n_reset = 1'b0;
    #3;
    check("rst.outs", 32'({busy, gnt0, gnt1, done0, done1, mem_cs, mem_r_nw}), 32'd0);
    check("rst.bus", 32'({mem_addr, mem_wdata, rdata}), 32'd0);
    @(negedge clock);
    n_reset = 1'b1;
    step();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5'h07; wdata[0] = 8'h5A;
    step();
    check("abort.pre_cs", 32'(mem_cs), 32'd1);
    #2 n_reset = 1'b0;
    #1;
    check("abort.cs", 32'(mem_cs), 32'd0);
    check("abort.gnt0", 32'(gnt0), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    req[0] = 1'b0;
    #10 n_reset = 1'b1;
    step();
    check("abort.after_outs", 32'({busy, gnt0, gnt1, done0, done1, mem_cs, mem_r_nw}), 32'd0);
    check("abort.after_bus", 32'({mem_addr, mem_wdata, rdata}), 32'd0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done0 || busy) cnt++;
    end
    check("abort.no_done", 32'(cnt), 32'd0);

    // Simultaneous held requests.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5'h08; wdata[0] = 8'h80;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 5'h09; wdata[1] = 8'h91;
    for (int k = 0; k < 4; k++) begin
      wait_gnt("tie", owner);
      check("tie.order", 32'(owner), RR ? 32'(k % 2) : 32'd0);
      wait_done("tie", owner);
    end
    req[0] = 1'b0;
    wait_gnt("tie_tail", owner);
    check("tie_tail.owner", 32'(owner), 32'd1);
    wait_done("tie_tail", 1);
    req[1] = 1'b0;
    step();
    check("tie_tail.idle", 32'(busy), 32'd0);
    ref_mem[8] = 8'h80;
    ref_mem[9] = 8'h91;

    for (int i = 0; i < 7; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

    // Port 0 read with req dropped during READ.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 5'h03; wdata[0] = 8'h00;
    step();
    check("drop.cs", 32'({mem_cs, mem_r_nw}), 32'b11);
    step();
    req[0] = 1'b0;
    check("drop.read", 32'({mem_cs, done0}), 32'd0);
    step();
    check("drop.done", 32'(done0), 32'd1);
    check("drop.rdata", 32'(rdata), 32'hA5);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (mem_cs || done0) cnt++;
    end
    check("drop.no_extra", 32'(cnt), 32'd0);

    // Port 0 read with req held through DONE: two pulses four cycles apart.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 5'h1F; wdata[0] = 8'h00;
    np = 0; d1 = -1; d2 = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (done0) begin
        np++;
        check("held.rdata", 32'(rdata), 32'h3C);
        if (np == 1) d1 = i;
        else begin
          d2 = i;
          req[0] = 1'b0;
        end
      end
    end
    check("held.pulses", 32'(np), 32'd2);
    check("held.gap", 32'(d2 - d1), 32'd4);
    check("held.idle", 32'(busy), 32'd0);

    // Random two-port traffic against a transaction-level model.
    t_v = 1'b0; t_start = 0; t_len = 0; t_own = 0; t_we = 1'b0; t_addr = '0;
    m_addr = 5'h1F; m_wdata = 8'h00; m_rd = 8'h3C; m_last = 0;
    pend[0] = 1'b0; pend[1] = 1'b0; latched[0] = 1'b0; latched[1] = 1'b0;
    for (int c = 0; c < 500; c++) begin
      bit   act;
      int   off;
      logic [27:0] exp_v, got_v;
      off = c - t_start;
      act = t_v && off >= 1 && off <= t_len;
      if (act && off == 1 && t_we) ref_mem[t_addr] = m_wdata;
      if (act && off == t_len) begin
        if (!t_we) m_rd = ref_mem[t_addr];
        m_last = t_own;
      end
      exp_v = {act, act && t_own == 0, act && t_own == 1,
               act && off == t_len && t_own == 0, act && off == t_len && t_own == 1,
               act && off == 1, act && off == 1 && !t_we, m_addr, m_wdata, m_rd};
      got_v = {busy, gnt0, gnt1, done0, done1, mem_cs, mem_r_nw, mem_addr, mem_wdata, rdata};
      check("rand", 32'(got_v), 32'(exp_v));
      if (act && off == t_len) begin
        pend[t_own] = 1'b0; latched[t_own] = 1'b0; req[t_own] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 3) == 0) begin
            pend[p] = 1'b1; req[p] = 1'b1;
            we[p] = 1'($urandom_range(0, 1));
            addr[p] = 5'($urandom_range(0, 31));
            wdata[p] = 8'($urandom_range(0, 255));
          end
        end else if (latched[p]) begin
          if ($urandom_range(0, 7) == 0) req[p] = 1'b0;
          if ($urandom_range(0, 3) == 0) begin
            addr[p] = 5'($urandom_range(0, 31));
            wdata[p] = 8'($urandom_range(0, 255));
          end
        end
      end
      if (!act && (req[0] || req[1])) begin
        if (req[0] && req[1]) t_own = RR ? ((m_last == 1) ? 0 : 1) : 0;
        else t_own = req[0] ? 0 : 1;
        t_v = 1'b1; t_start = c; t_we = we[t_own]; t_addr = addr[t_own];
        t_len = t_we ? 2 : 3;
        m_addr = addr[t_own]; m_wdata = wdata[t_own];
        latched[t_own] = 1'b1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
